// File: rtl/scan_counter_2d.sv
// Raster-order 2-D stride counter producing (x,y) window origins over a valid/ready stream.
// Optional frame counter enabled by defining SCAN_FRAME_CNT_EN.
module scan_counter_2d #(
  parameter int DATA_WIDTH      = 8,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] x_max,
  input  logic [DATA_WIDTH-1:0] y_max,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic                  coord_ready,
  output logic                  coord_valid,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  last_col,
  output logic                  last_row,
  output logic                  busy,
  output logic                  done
`ifdef SCAN_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] xm_q;
  logic [DATA_WIDTH-1:0] ym_q;
  logic [DATA_WIDTH-1:0] step_q;
  logic [DATA_WIDTH:0]   x_sum;
  logic [DATA_WIDTH:0]   y_sum;
  logic                  in_scan;

  // One extra bit so a stride past the top of the range compares as "beyond bound" instead of wrapping.
  assign x_sum   = {1'b0, x_out} + {1'b0, step_q};
  assign y_sum   = {1'b0, y_out} + {1'b0, step_q};
  assign in_scan = (state == S_SCAN);

  assign last_col = in_scan && (x_sum > {1'b0, xm_q});
  assign last_row = in_scan && (y_sum > {1'b0, ym_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      xm_q        <= '0;
      ym_q        <= '0;
      step_q      <= '0;
      x_out       <= '0;
      y_out       <= '0;
      coord_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SCAN_FRAME_CNT_EN
      frame_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            xm_q        <= x_max;
            ym_q        <= y_max;
            step_q      <= (step == '0) ? DATA_WIDTH'(1) : step;
            x_out       <= '0;
            y_out       <= '0;
            coord_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (coord_ready) begin
            if (!last_col) begin
              x_out <= x_sum[DATA_WIDTH-1:0];
            end else begin
              x_out <= '0;
              if (!last_row) begin
                y_out <= y_sum[DATA_WIDTH-1:0];
              end else begin
                y_out       <= '0;
                coord_valid <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
                state       <= S_DONE;
`ifdef SCAN_FRAME_CNT_EN
                frame_cnt   <= frame_cnt + FRAME_CNT_WIDTH'(1);
`endif
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          x_out <= '0;
          y_out <= '0;
          state <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          coord_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_counter_2d.sv
// Directed self-checking bench for scan_counter_2d; inputs driven and outputs sampled on negedge.
module tb_scan_counter_2d;

  logic       clk = 1'b0;
  logic       reset, start, coord_ready;
  logic [7:0] x_max, y_max, step;
  logic       coord_valid, last_col, last_row, busy, done;
  logic [7:0] x_out, y_out;
`ifdef SCAN_FRAME_CNT_EN
  logic [1:0] frame_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  scan_counter_2d #(
    .DATA_WIDTH(8)
`ifdef SCAN_FRAME_CNT_EN
    , .FRAME_CNT_WIDTH(2)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .x_max(x_max),
    .y_max(y_max),
    .step(step),
    .coord_ready(coord_ready),
    .coord_valid(coord_valid),
    .x_out(x_out),
    .y_out(y_out),
    .last_col(last_col),
    .last_row(last_row),
    .busy(busy),
    .done(done)
`ifdef SCAN_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, coord_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_x"}, x_out, 0);
    check({tag, "_y"}, y_out, 0);
    check({tag, "_lcol"}, last_col, 0);
    check({tag, "_lrow"}, last_row, 0);
  endtask

  // Runs a full scan with ready high, optionally stalling 3 cycles at (1,0).
  task automatic do_scan(input logic [7:0] xm, input logic [7:0] ym, input logic [7:0] st,
                         input int exp_n, input bit stall);
    int s, n;
    s = (st == 0) ? 1 : int'(st);
    n = 0;
    @(negedge clk);
    start = 1; x_max = xm; y_max = ym; step = st; coord_ready = 1;
    @(negedge clk);
    start = 1;  // held high: must be ignored during SCAN
    check("start_busy", busy, 1);
    for (int ey = 0; ey <= int'(ym); ey += s) begin
      for (int ex = 0; ex <= int'(xm); ex += s) begin
        check("coord_valid", coord_valid, 1);
        check("x", x_out, ex);
        check("y", y_out, ey);
        check("last_col", last_col, (ex + s > int'(xm)) ? 1 : 0);
        check("last_row", last_row, (ey + s > int'(ym)) ? 1 : 0);
        check("no_done", done, 0);
        n++;
        if (stall && ex == 1 && ey == 0) begin
          coord_ready = 0;
          repeat (3) begin
            @(negedge clk);
            check("hold_valid", coord_valid, 1);
            check("hold_x", x_out, 1);
            check("hold_y", y_out, 0);
          end
          coord_ready = 1;
        end
        @(negedge clk);
      end
    end
    check("coord_count", n, exp_n);
    check("done_pulse", done, 1);
    check("done_valid", coord_valid, 0);
    check("done_busy", busy, 0);
    check("done_x", x_out, 0);
    check("done_y", y_out, 0);
    start = 1;  // start in DONE cycle must be ignored
    @(negedge clk);
    start = 0;
    check_idle("after_done");
  endtask

  initial begin
    reset = 1; start = 0; coord_ready = 0; x_max = 0; y_max = 0; step = 0;
    repeat (2) @(negedge clk);
    check_idle("reset");
`ifdef SCAN_FRAME_CNT_EN
    check("reset_fcnt", frame_cnt, 0);
`endif
    reset = 0;
    @(negedge clk);
    check_idle("idle_no_start");

    do_scan(8'd2, 8'd1, 8'd1, 6, 1'b0);
    do_scan(8'd4, 8'd4, 8'd2, 9, 1'b0);
    do_scan(8'd3, 8'd1, 8'd1, 8, 1'b1);
    do_scan(8'd1, 8'd1, 8'd0, 4, 1'b0);
    do_scan(8'd250, 8'd0, 8'd10, 26, 1'b0);
    do_scan(8'd255, 8'd0, 8'd200, 2, 1'b0);
    do_scan(8'd0, 8'd2, 8'd1, 3, 1'b0);
    do_scan(8'd0, 8'd0, 8'd5, 1, 1'b0);

    // Reset mid-scan at (1,1) with start held high.
    @(negedge clk);
    start = 1; x_max = 2; y_max = 2; step = 1; coord_ready = 1;
    repeat (5) @(negedge clk);
    check("pre_rst_x", x_out, 1);
    check("pre_rst_y", y_out, 1);
    check("pre_rst_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    check_idle("mid_reset");
    reset = 0; start = 0;
    @(negedge clk);
    check_idle("post_reset");

`ifdef SCAN_FRAME_CNT_EN
    begin
      logic [1:0] exp_cnt [5];
      exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 0; exp_cnt[4] = 1;
      reset = 1;
      @(negedge clk);
      reset = 0;
      for (int k = 0; k < 5; k++) begin
        do_scan(8'd0, 8'd0, 8'd1, 1, 1'b0);
        check("frame_cnt", frame_cnt, exp_cnt[k]);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
